// File: rtl/alu_seq.sv
// alu_seq: sequences operand loads, execute and capture on an external ALU over a shared tri-state bus.
// Optional macro ALU_SEQ_SKIP_EN caches ALU reg0/reg1 contents and skips redundant loads.
module alu_seq #(
    parameter int BITW = 8
) (
    input  logic            clock,
    input  logic            n_reset,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [1:0]      cmd_op,
    input  logic [BITW-1:0] cmd_a,
    input  logic [BITW-1:0] cmd_b,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [BITW-1:0] rsp_data,
    output logic [2:0]      alu_op,
    inout  wire  [BITW-1:0] bus
);

    localparam logic [1:0] OP_ADD  = 2'd0;
    localparam logic [1:0] OP_SUB  = 2'd1;
    localparam logic [1:0] OP_INC  = 2'd2;
    localparam logic [1:0] OP_PASS = 2'd3;

    localparam logic [2:0] A_NOP = 3'd0;
    localparam logic [2:0] A_ADD = 3'd1;
    localparam logic [2:0] A_INC = 3'd2;
    localparam logic [2:0] A_SUB = 3'd3;
    localparam logic [2:0] A_RD0 = 3'd4;
    localparam logic [2:0] A_WR0 = 3'd6;
    localparam logic [2:0] A_WR1 = 3'd7;

    typedef enum logic [2:0] {
        IDLE, LOAD_A, LOAD_B, EXEC, CAPTURE, RESP
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [BITW-1:0] a_q, a_d;
    logic [BITW-1:0] b_q, b_d;
    logic [BITW-1:0] rsp_data_q, rsp_data_d;
    logic            bus_drv;
    logic [BITW-1:0] bus_val;

    // hit_*_new compares against the incoming command, hit_b_reg against the registered one
    logic hit_a_new, hit_b_new, hit_b_reg;

`ifdef ALU_SEQ_SKIP_EN
    logic [BITW-1:0] c0_q, c1_q;
    logic            c0_vld_q, c1_vld_q;

    assign hit_a_new = c0_vld_q && (c0_q == cmd_a);
    assign hit_b_new = c1_vld_q && (c1_q == cmd_b);
    assign hit_b_reg = c1_vld_q && (c1_q == b_q);

    // Mirror of what the ALU registers hold, updated by every load we issue
    always_ff @(posedge clock) begin
        if (!n_reset) begin
            c0_q     <= '0;
            c1_q     <= '0;
            c0_vld_q <= 1'b0;
            c1_vld_q <= 1'b0;
        end else begin
            if (state_q == LOAD_A) begin
                c0_q     <= a_q;
                c0_vld_q <= 1'b1;
            end
            if (state_q == LOAD_B) begin
                c1_q     <= b_q;
                c1_vld_q <= 1'b1;
            end
        end
    end
`else
    assign hit_a_new = 1'b0;
    assign hit_b_new = 1'b0;
    assign hit_b_reg = 1'b0;
`endif

    assign bus      = bus_drv ? bus_val : {BITW{1'bz}};
    assign rsp_data = rsp_data_q;

    // State and command/result registers
    always_ff @(posedge clock) begin
        if (!n_reset) begin
            state_q    <= IDLE;
            op_q       <= OP_ADD;
            a_q        <= '0;
            b_q        <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    // Next-state, bus drive and ALU opcode decode
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        rsp_data_d = rsp_data_q;
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        alu_op     = A_NOP;
        bus_drv    = 1'b0;
        bus_val    = '0;
        unique case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    op_d = cmd_op;
                    a_d  = cmd_a;
                    b_d  = cmd_b;
                    if (cmd_op == OP_INC)
                        state_d = hit_b_new ? EXEC : LOAD_B;
                    else if (cmd_op == OP_PASS)
                        state_d = hit_a_new ? EXEC : LOAD_A;
                    else if (!hit_a_new)
                        state_d = LOAD_A;
                    else
                        state_d = hit_b_new ? EXEC : LOAD_B;
                end
            end
            LOAD_A: begin
                bus_drv = 1'b1;
                bus_val = a_q;
                alu_op  = A_WR0;
                state_d = (op_q == OP_PASS || hit_b_reg) ? EXEC : LOAD_B;
            end
            LOAD_B: begin
                bus_drv = 1'b1;
                bus_val = b_q;
                alu_op  = A_WR1;
                state_d = EXEC;
            end
            EXEC: begin
                unique case (op_q)
                    OP_ADD:  alu_op = A_ADD;
                    OP_SUB:  alu_op = A_SUB;
                    OP_INC:  alu_op = A_INC;
                    OP_PASS: alu_op = A_RD0;
                    default: alu_op = A_NOP;
                endcase
                state_d = CAPTURE;
            end
            CAPTURE: begin
                rsp_data_d = bus;
                state_d    = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: table-driven check of alu_seq against a behavioural ALU on the shared bus.
// Expectations follow ALU_SEQ_SKIP_EN when the bench is built with that macro.
module tb_alu_seq;

    logic       clock = 1'b0;
    logic       n_reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_a, cmd_b;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic [2:0] alu_op;
    wire  [7:0] bus;

    always #5 clock = ~clock;

    alu_seq #(.BITW(8)) dut (
        .clock(clock), .n_reset(n_reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .alu_op(alu_op), .bus(bus)
    );

    // External ALU: registers written from the bus, result driven the cycle after issue
    logic [7:0] r0 = 8'h0, r1 = 8'h0, ares = 8'h0;
    logic       aen = 1'b0;
    assign bus = aen ? ares : 8'bz;

    always @(posedge clock) begin
        aen <= 1'b0;
        case (alu_op)
            3'd1: begin ares <= r0 + r1; aen <= 1'b1; end
            3'd2: begin ares <= r1 + 8'd1; aen <= 1'b1; end
            3'd3: begin ares <= r0 - r1; aen <= 1'b1; end
            3'd4: begin ares <= r0; aen <= 1'b1; end
            3'd5: begin ares <= r1; aen <= 1'b1; end
            3'd6: r0 <= bus;
            3'd7: r1 <= bus;
            default: ;
        endcase
    end

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  a, b, d;
        int          lat;
        logic [17:0] seq;
    } vec_t;

    int         n_vec = 0;
    int         n_bad = 0;
    logic [7:0] sb[$];
    vec_t       tbl[$];

    function automatic logic [17:0] sq(input logic [2:0] o0, o1, o2, o3);
        return {6'b0, o3, o2, o1, o0};
    endfunction

    function automatic vec_t mk(input logic [1:0] op, input logic [7:0] a, b, d,
                                input int lat, input logic [17:0] seq);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.d = d; v.lat = lat; v.seq = seq;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, got, exp);
        end
    endtask

    task automatic run(input vec_t v, input int hold);
        int          cyc;
        logic        got;
        logic [17:0] rec;
        logic [7:0]  e;
        @(negedge clock);
        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op = v.op; cmd_a = v.a; cmd_b = v.b;
        sb.push_back(v.d);
        @(posedge clock);
        #1;
        cmd_a = 8'($urandom);
        cmd_b = 8'($urandom);
        cmd_op = 2'($urandom);
        cyc = 0; got = 1'b0; rec = '0;
        while (!got && cyc < 20) begin
            @(negedge clock);
            cyc++;
            if (rsp_valid) begin
                got = 1'b1;
                cmd_valid = 1'b0;
            end else begin
                if (cyc <= 6) rec = rec | (18'(alu_op) << (3 * (cyc - 1)));
                if (alu_op == 3'd6) chk("bus_a", bus, v.a);
                if (alu_op == 3'd7) chk("bus_b", bus, v.b);
                chk("bus_contention", aen && (alu_op == 3'd6 || alu_op == 3'd7), 0);
                chk("cmd_ready_busy", cmd_ready, 0);
            end
        end
        cmd_valid = 1'b0;
        if (!got) begin
            n_vec++; n_bad++;
            $display("FAIL rsp_timeout: got no rsp_valid want rsp_valid within 20 cycles");
            return;
        end
        chk("latency", cyc, v.lat);
        chk("alu_op_seq", rec, v.seq);
        if (sb.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL scoreboard: got response want none");
        end else begin
            e = sb.pop_front();
            chk("rsp_data", rsp_data, e);
            if (hold > 0) begin
                repeat (hold - 1) begin
                    @(negedge clock);
                    chk("hold_valid", rsp_valid, 1);
                    chk("hold_data", rsp_data, e);
                    chk("hold_cmd_ready", cmd_ready, 0);
                end
                @(negedge clock);
                rsp_ready = 1'b1;
                chk("rel_valid", rsp_valid, 1);
                chk("rel_cmd_ready", cmd_ready, 0);
            end
        end
        @(negedge clock);
        chk("done_valid", rsp_valid, 0);
        chk("done_cmd_ready", cmd_ready, 1);
    endtask

    initial begin
        n_reset = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b1;
        cmd_op = 2'd0; cmd_a = 8'h0; cmd_b = 8'h0;

        tbl.push_back(mk(2'd0, 8'h05, 8'h03, 8'h08, 5, sq(6, 7, 1, 0)));
        tbl.push_back(mk(2'd1, 8'h03, 8'h05, 8'hFE, 5, sq(6, 7, 3, 0)));
        tbl.push_back(mk(2'd2, 8'h11, 8'hFF, 8'h00, 4, sq(7, 2, 0, 0)));
        tbl.push_back(mk(2'd3, 8'hA5, 8'h00, 8'hA5, 4, sq(6, 4, 0, 0)));
        tbl.push_back(mk(2'd0, 8'h07, 8'h09, 8'h10, 5, sq(6, 7, 1, 0)));
`ifdef ALU_SEQ_SKIP_EN
        tbl.push_back(mk(2'd0, 8'h07, 8'h09, 8'h10, 3, sq(1, 0, 0, 0)));
        tbl.push_back(mk(2'd0, 8'h07, 8'h01, 8'h08, 4, sq(7, 1, 0, 0)));
        tbl.push_back(mk(2'd1, 8'h00, 8'h01, 8'hFF, 4, sq(6, 3, 0, 0)));
        tbl.push_back(mk(2'd0, 8'hFF, 8'h01, 8'h00, 4, sq(6, 1, 0, 0)));
`else
        tbl.push_back(mk(2'd0, 8'h07, 8'h09, 8'h10, 5, sq(6, 7, 1, 0)));
        tbl.push_back(mk(2'd0, 8'h07, 8'h01, 8'h08, 5, sq(6, 7, 1, 0)));
        tbl.push_back(mk(2'd1, 8'h00, 8'h01, 8'hFF, 5, sq(6, 7, 3, 0)));
        tbl.push_back(mk(2'd0, 8'hFF, 8'h01, 8'h00, 5, sq(6, 7, 1, 0)));
`endif

        repeat (3) @(negedge clock);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_alu_op", alu_op, 0);
        n_reset = 1'b1;
        @(negedge clock);
        chk("rst_cmd_ready", cmd_ready, 1);

        foreach (tbl[i]) run(tbl[i], 0);

        rsp_ready = 1'b0;
        run(mk(2'd0, 8'h01, 8'h02, 8'h03, 5, sq(6, 7, 1, 0)), 3);

        @(negedge clock);
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_a = 8'h04; cmd_b = 8'h04;
        @(posedge clock);
        #1 cmd_valid = 1'b0;
        repeat (3) @(negedge clock);
        chk("abort_in_exec", alu_op, 1);
        n_reset = 1'b0;
        @(negedge clock);
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_alu_op", alu_op, 0);
        chk("abort_cmd_ready", cmd_ready, 1);
        n_reset = 1'b1;
        repeat (3) begin
            @(negedge clock);
            chk("abort_no_rsp", rsp_valid, 0);
        end
        run(mk(2'd0, 8'h04, 8'h04, 8'h08, 5, sq(6, 7, 1, 0)), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
